// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the serial transmit scheduler.
// The optional parity bit is enabled by defining SERIAL_TX_PARITY_EN.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_GAP    = 2'd3
    } state_e;

    // Width of an index or counter covering n values; never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_tx_scheduler_if.sv
// Requester-side bus and serial output of the transmit scheduler.
// master = requester/pin side, slave = scheduler.
interface serial_tx_scheduler_if
    import serial_tx_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int IW = idx_w(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  sout;
    logic                  sout_en;
    logic                  frame_start;
    logic [IW-1:0]         grant_id;
    logic                  busy;

    modport master (
        output req_valid, req_data,
        input  req_ready, sout, sout_en, frame_start, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, sout, sout_en, frame_start, grant_id, busy
    );

endinterface

// File: rtl/serial_tx_scheduler_arb.sv
// Round-robin arbiter: grants the first requester at or after the one
// following the last grant. The pointer only moves when a grant is taken.
module rr_arbiter
    import serial_tx_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    logic [IW-1:0]   last_q;
    logic [NREQ-1:0] gnt;
    int              j;

    // Scan requesters starting one past the last grant, wrapping around.
    always_comb begin
        gnt   = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(last_q) + 1 + k) % NREQ;
            if (!any_o && req_i[j]) begin
                any_o  = 1'b1;
                gnt[j] = 1'b1;
                idx_o  = IW'(j);
            end
        end
    end

    assign gnt_o = en_i ? gnt : '0;

    // Remember the last winner; reset makes requester 0 the first candidate.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            last_q <= IW'(NREQ - 1);
        else if (en_i && any_o)
            last_q <= idx_o;
    end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Shares one LSB-first serializer among NREQ requesters with round-robin
// grants and a fixed idle gap after each frame.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit to every frame.
module serial_tx_scheduler
    import serial_tx_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic                 clk,
    input  logic                 rst_b,
    serial_tx_scheduler_if.slave bus
);

    localparam int IW = idx_w(NREQ);
    localparam int BW = idx_w(WIDTH);
    localparam int GW = idx_w(GAP + 1);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_SHIFT = ST_SHIFT;
    localparam logic [1:0] S_GAP   = ST_GAP;
    localparam logic [1:0] S_POST  = (GAP > 0) ? S_GAP : S_IDLE;
`ifdef SERIAL_TX_PARITY_EN
    localparam logic [1:0] S_PARITY = ST_PARITY;
    localparam logic [1:0] S_TAIL   = S_PARITY;
`else
    localparam logic [1:0] S_TAIL   = S_POST;
`endif

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic [IW-1:0]    gid_q, gid_d;
`ifdef SERIAL_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    logic [NREQ-1:0]  gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;
    logic             arb_en;
    logic             take;
    logic [WIDTH-1:0] word;

    // Grants only exist in IDLE; reset also masks them so the pins read 0.
    assign arb_en = (state_q == S_IDLE) && rst_b;
    assign take   = arb_en && arb_any;
    assign word   = bus.req_data[arb_idx*WIDTH +: WIDTH];

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk   (clk),
        .rst_b (rst_b),
        .req_i (bus.req_valid),
        .en_i  (arb_en),
        .gnt_o (gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Frame sequencing: load on grant, shift WIDTH bits, optional parity, gap.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        bcnt_d  = bcnt_q;
        gcnt_d  = gcnt_q;
        gid_d   = gid_q;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (take) begin
                    sreg_d  = word;
                    gid_d   = arb_idx;
                    bcnt_d  = '0;
                    state_d = S_SHIFT;
`ifdef SERIAL_TX_PARITY_EN
                    par_d   = ^word;
`endif
                end
            end
            S_SHIFT: begin
                sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
                if (bcnt_q == BIT_LAST) begin
                    bcnt_d  = '0;
                    state_d = S_TAIL;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: state_d = S_POST;
`endif
            S_GAP: begin
                if (gcnt_q == GAP_LAST) begin
                    gcnt_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            bcnt_q  <= '0;
            gcnt_q  <= '0;
            gid_q   <= '0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            bcnt_q  <= bcnt_d;
            gcnt_q  <= gcnt_d;
            gid_q   <= gid_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.req_ready   = gnt;
    assign bus.grant_id    = gid_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.frame_start = (state_q == S_SHIFT) && (bcnt_q == '0);
`ifdef SERIAL_TX_PARITY_EN
    assign bus.sout_en     = (state_q == S_SHIFT) || (state_q == S_PARITY);
    assign bus.sout        = (state_q == S_SHIFT)  ? sreg_q[0] :
                             (state_q == S_PARITY) ? par_q : 1'b0;
`else
    assign bus.sout_en     = (state_q == S_SHIFT);
    assign bus.sout        = (state_q == S_SHIFT) ? sreg_q[0] : 1'b0;
`endif

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Bench for serial_tx_scheduler: directed scenarios plus random traffic,
// checked every cycle against a frame-timeline reference model.
module tb_serial_tx_scheduler;
    import serial_tx_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int GAP   = 1;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = WIDTH + PAR + GAP;  // busy cycles per frame

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    serial_tx_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    serial_tx_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .GAP(GAP)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    int vectors = 0;
    int errs    = 0;

    // Stimulus state
    logic [NREQ-1:0]       v;
    logic [NREQ*WIDTH-1:0] d;
    logic [NREQ-1:0]       keep;

    // Reference model: position within the frame timeline (0 = idle,
    // 1..WIDTH data bits, then optional parity, then gap cycles).
    int               m_pos;
    int               m_ptr;
    int               m_gid;
    logic [WIDTH-1:0] m_w;

    logic last_sout, last_fs;
    int   gq[$];

    function automatic int pick(input int ptr, input logic [NREQ-1:0] vv);
        for (int k = 0; k < NREQ; k++)
            if (vv[(ptr + 1 + k) % NREQ]) return (ptr + 1 + k) % NREQ;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.req_valid = v;
        bus.req_data  = d;
    endtask

    task automatic model_reset();
        m_pos = 0;
        m_ptr = NREQ - 1;
        m_gid = 0;
        m_w   = '0;
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0] er;
        logic es, een, efs;
        int g;
        er = '0; es = 1'b0; een = 1'b0; efs = 1'b0;
        if (m_pos >= 1 && m_pos <= WIDTH) begin
            es = m_w[m_pos-1]; een = 1'b1; efs = (m_pos == 1);
        end else if (PAR == 1 && m_pos == WIDTH + 1) begin
            es = ^m_w; een = 1'b1;
        end
        if (m_pos == 0) begin
            g = pick(m_ptr, v);
            if (g >= 0) er[g] = 1'b1;
        end
        chk("busy",        32'(bus.busy),        32'(m_pos != 0));
        chk("sout",        32'(bus.sout),        32'(es));
        chk("sout_en",     32'(bus.sout_en),     32'(een));
        chk("frame_start", 32'(bus.frame_start), 32'(efs));
        chk("grant_id",    32'(bus.grant_id),    32'(m_gid));
        chk("req_ready",   32'(bus.req_ready),   32'(er));
    endtask

    // One clock: check at the falling edge, advance the model past the rising edge.
    task automatic cyc();
        int g;
        @(negedge clk);
        check_outputs();
        last_sout = bus.sout;
        last_fs   = bus.frame_start;
        if (bus.frame_start) gq.push_back(int'(bus.grant_id));
        g = (m_pos == 0) ? pick(m_ptr, v) : -1;
        @(posedge clk);
        #1;
        if (g >= 0) begin
            m_w   = d[g*WIDTH +: WIDTH];
            m_gid = g;
            m_ptr = g;
            m_pos = 1;
            if (keep[g]) d[g*WIDTH +: WIDTH] = WIDTH'($urandom);
            else         v[g] = 1'b0;
        end else if (m_pos > 0) begin
            m_pos = (m_pos == FL) ? 0 : m_pos + 1;
        end
        drive();
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy",    32'(bus.busy),        32'd0);
        chk("rst_sout",    32'(bus.sout),        32'd0);
        chk("rst_sout_en", 32'(bus.sout_en),     32'd0);
        chk("rst_fs",      32'(bus.frame_start), 32'd0);
        chk("rst_gid",     32'(bus.grant_id),    32'd0);
        chk("rst_ready",   32'(bus.req_ready),   32'd0);
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1;
        rst_b = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] cap, fsv;
        int exp_g[5];
        v = '0; d = '0; keep = '0;
        drive();
        model_reset();

        // Reset state
        #2;
        check_reset_outputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_b = 1'b1;
        cyc();

        // Single requester 0 sending 8'hA5
        d[0 +: WIDTH] = 8'hA5;
        v[0] = 1'b1;
        drive();
        cyc();
        for (int i = 0; i < WIDTH; i++) begin
            cyc();
            cap[i] = last_sout;
            fsv[i] = last_fs;
        end
        chk("a5_bits", 32'(cap), 32'h0000_00A5);
        chk("a5_fs",   32'(fsv), 32'h0000_0001);
        for (int i = 0; i < GAP + 2; i++) cyc();

        // All requesters valid continuously from a fresh pointer
        do_reset();
        keep = '1;
        for (int i = 0; i < NREQ; i++) d[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        v = '1;
        drive();
        gq.delete();
        for (int i = 0; i < 5 * (FL + 1); i++) cyc();
        exp_g = '{0, 1, 2, 3, 0};
        chk("rr_count", 32'(gq.size()), 32'd5);
        for (int i = 0; i < 5 && i < gq.size(); i++) chk("rr_order", 32'(gq[i]), 32'(exp_g[i]));
        v = '0;
        drive();
        cyc();

        // Pointer wrap: grant 1, then 1 and 3 compete -> 3 then 1
        keep = '0;
        v[1] = 1'b1;
        drive();
        gq.delete();
        for (int i = 0; i < FL + 2; i++) cyc();
        keep = 4'b1010;
        v = 4'b1010;
        drive();
        for (int i = 0; i < 2 * (FL + 1) + 1; i++) cyc();
        chk("wrap_count", 32'(gq.size()), 32'd3);
        if (gq.size() == 3) begin
            chk("wrap_g0", 32'(gq[0]), 32'd1);
            chk("wrap_g1", 32'(gq[1]), 32'd3);
            chk("wrap_g2", 32'(gq[2]), 32'd1);
        end
        v = '0; keep = '0;
        drive();
        for (int i = 0; i < FL + 1; i++) cyc();

        // Reset at data bit 4 of a frame from requester 2
        v = 4'b0100;
        drive();
        for (int i = 0; i < 5; i++) cyc();
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        v = '1; keep = '1;
        drive();
        do_reset();
        gq.delete();
        for (int i = 0; i < FL + 2; i++) cyc();
        chk("post_rst_first", (gq.size() > 0) ? 32'(gq[0]) : 32'hFFFF_FFFF, 32'd0);
        v = '0; keep = '0;
        drive();
        for (int i = 0; i < FL + 1; i++) cyc();

        // Random traffic: arrivals, keeps and pre-grant withdrawals
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i] && $urandom_range(0, 9) < 3) begin
                    v[i] = 1'b1;
                    d[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                    keep[i] = ($urandom_range(0, 3) == 0);
                end else if (v[i] && $urandom_range(0, 19) == 0) begin
                    v[i] = 1'b0;
                end
            end
            drive();
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
